// File: rtl/nn_test_scorer.sv
// nn_test_scorer: re-streams every image from the pixel ROM, forms the dot product with the
// stored weight column, thresholds at z > 0 and scores each prediction against the fixed
// label split (first N_POS images are class 1).
module nn_test_scorer #(
  parameter int unsigned N_PIX = 784,
  parameter int unsigned N_IMG = 40,
  parameter int unsigned N_POS = 20,
  parameter int unsigned W_W   = 16,
  parameter int unsigned ACC_W = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    w_we,
  input  logic [9:0]              w_addr,
  input  logic [W_W-1:0]          w_data,
  output logic                    pix_en,
  output logic [14:0]             pix_addr,
  input  logic [7:0]              pix_data,
  output logic                    busy,
  output logic                    score_valid,
  output logic signed [ACC_W-1:0] score,
  output logic                    pred,
  output logic [5:0]              img_idx,
  output logic [5:0]              correct_cnt,
  output logic                    done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRIME = 3'd1;
  localparam logic [2:0] S_ACC   = 3'd2;
  localparam logic [2:0] S_EMIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Unsigned 8-bit pixel widened to 9 signed bits times a W_W-bit weight.
  localparam int unsigned PROD_W = W_W + 9;

  localparam logic [9:0]  PIX_END    = 10'(N_PIX);
  localparam logic [5:0]  IMG_LAST   = 6'(N_IMG - 1);
  localparam logic [5:0]  POS_LIM    = 6'(N_POS);
  localparam logic [14:0] PIX_STRIDE = 15'(N_PIX);

  logic [W_W-1:0]           wmem [N_PIX];
  logic [2:0]               state_q, state_d;
  logic [9:0]               pix_q;
  logic [5:0]               img_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  score_q;
  logic                     pred_q;
  logic [5:0]               img_idx_q;
  logic [5:0]               cnt_q;

  logic [9:0]               w_idx;
  logic [W_W-1:0]           w_rd;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic                     acc_pos;

  // Weight RAM: synchronous write only while idle, deliberately untouched by rst.
  always_ff @(posedge clk) begin
    if (w_we && (state_q == S_IDLE) && (w_addr < PIX_END)) begin
      wmem[w_addr] <= w_data;
    end
  end

  // Pixel data arriving now belongs to the address issued last cycle, i.e. index pix-1.
  always_comb begin
    w_idx   = (pix_q == 10'd0) ? 10'd0 : pix_q - 10'd1;
    w_rd    = wmem[w_idx];
    prod    = $signed({1'b0, pix_data}) * $signed(w_rd);
    acc_sum = acc_q + $signed({{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod});
    acc_pos = !acc_sum[ACC_W-1] && (acc_sum != '0);
  end

  // Next-state logic for the per-image PRIME/ACC/EMIT loop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_PRIME;
      S_PRIME: state_d = S_ACC;
      S_ACC:   if (pix_q == PIX_END) state_d = S_EMIT;
      S_EMIT:  state_d = (img_q == IMG_LAST) ? S_DONE : S_PRIME;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters, accumulator and the held result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pix_q     <= '0;
      img_q     <= '0;
      acc_q     <= '0;
      score_q   <= '0;
      pred_q    <= 1'b0;
      img_idx_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            img_q <= '0;
            cnt_q <= '0;
            pix_q <= '0;
          end
        end
        S_PRIME: begin
          acc_q <= '0;
          pix_q <= 10'd1;
        end
        S_ACC: begin
          acc_q <= acc_sum;
          if (pix_q != PIX_END) begin
            pix_q <= pix_q + 10'd1;
          end else begin
            // Capture the finished sum so it is presented during EMIT and held afterwards.
            score_q   <= acc_sum;
            pred_q    <= acc_pos;
            img_idx_q <= img_q;
          end
        end
        S_EMIT: begin
          if (pred_q == (img_q < POS_LIM)) cnt_q <= cnt_q + 6'd1;
          pix_q <= '0;
          if (img_q != IMG_LAST) img_q <= img_q + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // ROM request and status outputs decoded from the current state.
  always_comb begin
    busy        = (state_q != S_IDLE);
    score_valid = (state_q == S_EMIT);
    done        = (state_q == S_DONE);
    pix_en      = (state_q == S_PRIME) || ((state_q == S_ACC) && (pix_q != PIX_END));
    pix_addr    = pix_en ? (15'(img_q) * PIX_STRIDE + 15'(pix_q)) : 15'd0;
    score       = score_q;
    pred        = pred_q;
    img_idx     = img_idx_q;
    correct_cnt = cnt_q;
  end

endmodule

// File: tb/tb_nn_test_scorer.sv
// Directed bench for nn_test_scorer: full pixel column, reduced image count to keep runtime short.
module tb_nn_test_scorer;

  localparam int N_PIX   = 784;
  localparam int N_IMG   = 6;
  localparam int N_POS   = 3;
  localparam int PER_IMG = N_PIX + 2;
  localparam int PASS_K  = N_IMG * PER_IMG;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               w_we;
  logic [9:0]         w_addr;
  logic [15:0]        w_data;
  logic               pix_en;
  logic [14:0]        pix_addr;
  logic [7:0]         pix_data = 8'd0;
  logic               busy;
  logic               score_valid;
  logic signed [39:0] score;
  logic               pred;
  logic [5:0]         img_idx;
  logic [5:0]         correct_cnt;
  logic               done;

  nn_test_scorer #(
    .N_PIX(N_PIX), .N_IMG(N_IMG), .N_POS(N_POS), .W_W(16), .ACC_W(40)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .pix_en(pix_en), .pix_addr(pix_addr), .pix_data(pix_data), .busy(busy),
    .score_valid(score_valid), .score(score), .pred(pred), .img_idx(img_idx),
    .correct_cnt(correct_cnt), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pix_mode = 0;

  // Pixel ROM: 0 = arbitrary pattern, 1 = pixel 0 is 10 for positive images, else all 255.
  function automatic logic [7:0] rom_val(input logic [14:0] a);
    int img, p;
    img = int'(a) / N_PIX;
    p   = int'(a) % N_PIX;
    case (pix_mode)
      0:       return a[7:0] ^ 8'h5a;
      1:       return (p == 0 && img < N_POS) ? 8'd10 : 8'd0;
      default: return 8'd255;
    endcase
  endfunction

  always @(posedge clk) if (pix_en) pix_data <= rom_val(pix_addr);

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [39:0] rec_score [64];
  logic               rec_pred  [64];
  logic [5:0]         rec_idx   [64];
  int                 n_sv = 0;
  longint             first_sv_cyc = 0;
  int                 exp_addr = 0;
  int                 addr_bad = 0;
  int                 done_k = -1;
  longint             t0 = 0;

  // Records score pulses and checks the ROM address stream stays strictly sequential.
  always @(negedge clk) begin
    if (score_valid) begin
      if (n_sv == 0) first_sv_cyc = cyc;
      if (n_sv < 64) begin
        rec_score[n_sv] = score;
        rec_pred[n_sv]  = pred;
        rec_idx[n_sv]   = img_idx;
      end
      n_sv++;
    end
    if (pix_en) begin
      if (int'(pix_addr) != exp_addr) addr_bad++;
      exp_addr++;
    end
  end

  function automatic logic [15:0] wval(input int wmode, input int i);
    case (wmode)
      0:       return 16'h0000;
      1:       return (i == 0) ? 16'd256 : 16'h0000;
      2:       return 16'hffff;
      default: return 16'h7fff;
    endcase
  endfunction

  task automatic load_weights(input int wmode);
    for (int i = 1; i < N_PIX; i++) begin
      @(negedge clk);
      w_we = 1'b1; w_addr = 10'(i); w_data = wval(wmode, i);
    end
    @(negedge clk);
    w_we = 1'b0;
  endtask

  // Starts a pass (optionally with a write in the same cycle) and follows it to done.
  task automatic run_pass(input bit wr, input logic [9:0] wa, input logic [15:0] wd,
                          input bit poke, input int abort_k);
    n_sv = 0; exp_addr = 0; addr_bad = 0; done_k = -1;
    @(negedge clk);
    start = 1'b1; w_we = wr; w_addr = wa; w_data = wd;
    for (int k = 0; k <= PASS_K + 20; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0; w_we = 1'b0; t0 = cyc;
      end
      if (poke) begin
        if (k == 100 || k == PER_IMG) begin
          start = 1'b1; w_we = 1'b1; w_addr = 10'd0; w_data = 16'h7fff;
        end else if (k == 101 || k == PER_IMG + 1) begin
          start = 1'b0; w_we = 1'b0;
        end
      end
      if (k == abort_k) return;
      if (done) begin
        done_k = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; w_we = 1'b0; w_addr = '0; w_data = '0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0 || score_valid !== 1'b0 || pix_en !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: done=%b sv=%b pix_en=%b want 0", done, score_valid, pix_en);
    end
    checks++; if (score !== 40'sd0 || pred !== 1'b0) begin
      errors++; $display("FAIL reset_score: got %0d/%b want 0/0", score, pred);
    end
    checks++; if (img_idx !== 6'd0 || correct_cnt !== 6'd0 || pix_addr !== 15'd0) begin
      errors++; $display("FAIL reset_regs: idx=%0d cnt=%0d addr=%0d want 0", img_idx, correct_cnt, pix_addr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Loads a weight set (weight 0 written in the same cycle as start) and scores one pass.
  task automatic test_pass(input string name, input int wmode, input int pmode,
                           input logic signed [39:0] s_pos, input logic signed [39:0] s_neg,
                           input int exp_cnt);
    logic signed [39:0] es;
    pix_mode = pmode;
    load_weights(wmode);
    run_pass(1'b1, 10'd0, wval(wmode, 0), 1'b0, -1);
    checks++; if (done_k != PASS_K) begin
      errors++; $display("FAIL %s_done_time: got %0d want %0d", name, done_k, PASS_K);
    end
    checks++; if (first_sv_cyc - t0 != longint'(N_PIX + 1)) begin
      errors++; $display("FAIL %s_first_sv: got %0d want %0d", name, first_sv_cyc - t0, N_PIX + 1);
    end
    checks++; if (n_sv != N_IMG) begin
      errors++; $display("FAIL %s_n_scores: got %0d want %0d", name, n_sv, N_IMG);
    end
    for (int i = 0; i < N_IMG; i++) begin
      es = (i < N_POS) ? s_pos : s_neg;
      checks++; if (rec_score[i] !== es) begin
        errors++; $display("FAIL %s_score[%0d]: got %0d want %0d", name, i, rec_score[i], es);
      end
      checks++; if (rec_pred[i] !== (es > 0)) begin
        errors++; $display("FAIL %s_pred[%0d]: got %b want %b", name, i, rec_pred[i], es > 0);
      end
      checks++; if (rec_idx[i] !== 6'(i)) begin
        errors++; $display("FAIL %s_idx[%0d]: got %0d want %0d", name, i, rec_idx[i], i);
      end
    end
    checks++; if (correct_cnt !== 6'(exp_cnt)) begin
      errors++; $display("FAIL %s_correct: got %0d want %0d", name, correct_cnt, exp_cnt);
    end
    checks++; if (addr_bad != 0 || exp_addr != N_IMG * N_PIX) begin
      errors++; $display("FAIL %s_addr_seq: bad=%0d count=%0d want 0/%0d", name, addr_bad, exp_addr, N_IMG * N_PIX);
    end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || score !== s_neg || img_idx !== 6'(N_IMG - 1) ||
                  correct_cnt !== 6'(exp_cnt)) begin
      errors++; $display("FAIL %s_hold: busy=%b score=%0d idx=%0d cnt=%0d want 0/%0d/%0d/%0d",
                         name, busy, score, img_idx, correct_cnt, s_neg, N_IMG - 1, exp_cnt);
    end
  endtask

  // Aborts during image 5 accumulation, then reruns with the retained weights.
  task automatic test_reset_mid_pass();
    pix_mode = 1;
    run_pass(1'b0, 10'd0, 16'd0, 1'b0, 5 * PER_IMG + 100);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_precond_busy: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || pix_en !== 1'b0 || pix_addr !== 15'd0 || score_valid !== 1'b0) begin
      errors++; $display("FAIL abort_outputs: busy=%b pix_en=%b addr=%0d sv=%b want 0", busy, pix_en, pix_addr, score_valid);
    end
    checks++; if (score !== 40'sd0 || correct_cnt !== 6'd0 || img_idx !== 6'd0 || pred !== 1'b0) begin
      errors++; $display("FAIL abort_regs: score=%0d cnt=%0d idx=%0d pred=%b want 0", score, correct_cnt, img_idx, pred);
    end
    @(negedge clk);
    rst = 1'b0;
    run_pass(1'b0, 10'd0, 16'd0, 1'b0, -1);
    checks++; if (done_k != PASS_K || n_sv != N_IMG) begin
      errors++; $display("FAIL rerun_timing: done_k=%0d n=%0d want %0d/%0d", done_k, n_sv, PASS_K, N_IMG);
    end
    for (int i = 0; i < N_IMG; i++) begin
      checks++; if (rec_score[i] !== ((i < N_POS) ? 40'sd2560 : 40'sd0)) begin
        errors++; $display("FAIL rerun_score[%0d]: got %0d want %0d", i, rec_score[i], (i < N_POS) ? 2560 : 0);
      end
    end
    checks++; if (correct_cnt !== 6'd6) begin
      errors++; $display("FAIL rerun_correct: got %0d want 6", correct_cnt);
    end
  endtask

  // start/w_we pulses while busy (and start in the DONE cycle) must be ignored.
  task automatic test_busy_pokes();
    pix_mode = 1;
    run_pass(1'b0, 10'd0, 16'd0, 1'b1, -1);
    checks++; if (done_k != PASS_K) begin
      errors++; $display("FAIL poke_done_time: got %0d want %0d", done_k, PASS_K);
    end
    checks++; if (addr_bad != 0 || exp_addr != N_IMG * N_PIX) begin
      errors++; $display("FAIL poke_addr_seq: bad=%0d count=%0d want 0/%0d", addr_bad, exp_addr, N_IMG * N_PIX);
    end
    for (int i = 0; i < N_IMG; i++) begin
      checks++; if (rec_score[i] !== ((i < N_POS) ? 40'sd2560 : 40'sd0)) begin
        errors++; $display("FAIL poke_score[%0d]: got %0d want %0d", i, rec_score[i], (i < N_POS) ? 2560 : 0);
      end
    end
    checks++; if (correct_cnt !== 6'd6) begin
      errors++; $display("FAIL poke_correct: got %0d want 6", correct_cnt);
    end
    // Still in the DONE cycle here.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin
      errors++; $display("FAIL poke_start_in_done: busy=%b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_pass("zero_w", 0, 0, 40'sd0, 40'sd0, 3);
    test_pass("single_w", 1, 1, 40'sd2560, 40'sd0, 6);
    test_reset_mid_pass();
    test_busy_pokes();
    test_pass("neg_w", 2, 2, -40'sd199920, -40'sd199920, 3);
    test_pass("max_w", 3, 2, 40'sd6550778640, 40'sd6550778640, 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nn_test_scorer.md
# nn_test_scorer

Inference-side evaluator downstream of the training datapath. Accepts the trained 784-entry weight column over a write port, then re-streams every image from the shared pixel block ROM, forms z = Σ pixel·weight per image, and thresholds at z > 0, which is equivalent to sigmoid(z) > 0.5. Each prediction is compared with the fixed label split (first N_POS images are class 1, the rest class 0), and the block reports per-image scores plus a running correct count.

## Interface
- N_PIX, 784, pixels per image (ROM column length)
- N_IMG, 40, images per pass
- N_POS, 20, images with index < N_POS have label 1; all others have label 0
- W_W, 16, weight width, two's complement, 8 fractional bits
- ACC_W, 40, accumulator/score width, signed
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle request to begin a pass
- w_we  in  1  weight write strobe
- w_addr  in  10  weight index 0..N_PIX-1
- w_data  in  W_W  weight value
- pix_en  out  1  ROM read enable
- pix_addr  out  15  ROM address = img·N_PIX + pix
- pix_data  in  8  unsigned pixel, valid exactly one cycle after pix_en
- busy  out  1  pass in progress
- score_valid  out  1  one-cycle pulse per image
- score  out  ACC_W  z of the image just finished
- pred  out  1  score > 0
- img_idx  out  6  index of the image reported by score_valid
- correct_cnt  out  6  running count of correct predictions this pass
- done  out  1  one-cycle pulse after the last image

## Operation
- Internal weight RAM holds N_PIX × W_W entries. It has a combinational read and a synchronous write.
- Weight RAM is not cleared by rst. Its contents persist across passes and across resets.
- w_we is honoured only in IDLE. It is ignored while busy. An out-of-range w_addr (≥ N_PIX) is ignored.
- FSM states:
  - IDLE: start → PRIME. Entering PRIME clears img to 0 and correct_cnt to 0.
  - PRIME: pix_en=1, pix_addr=img·N_PIX. Clear acc to 0. Set pix to 1. → ACC.
  - ACC: each cycle, acc += $signed({1'b0,pix_data}) · weight[pix−1], sign-extended to ACC_W.
    - While pix < N_PIX: pix_en=1, pix_addr=img·N_PIX+pix, pix++.
    - At pix = N_PIX: pix_en=0. The cycle is the last accumulate. → EMIT.
  - EMIT: drive score_valid=1, score=acc, pred=(acc>0), img_idx=img.
    - If pred == (img<N_POS), increment correct_cnt in the same cycle (visible next cycle).
    - If img = N_IMG−1 → DONE. Otherwise img++ and → PRIME.
  - DONE: done=1 for one cycle, busy deasserts. → IDLE.
- Arithmetic rules:
  - Each product is ≤ 25 bits.
  - ACC_W=40 covers N_PIX·255·32767 with no overflow, so no saturation logic is required.
  - z = 0 predicts class 0.
- start while busy is ignored.
- start and w_we in the same IDLE cycle: the write commits and the start is accepted. The PRIME cycle reads no weights, so no hazard arises.
- score, pred, img_idx and correct_cnt hold their values after done until the next start.

## Timing
- Reset values: busy 0, done 0, score_valid 0, score 0, pred 0, img_idx 0, correct_cnt 0, pix_en 0, pix_addr 0. FSM resets to IDLE.
- Start sampled at edge T: busy=1 from T+1 (PRIME) until the DONE cycle inclusive.
- Per image: N_PIX+2 cycles, made up of 1 PRIME, N_PIX ACC and 1 EMIT.
- First score_valid occurs at cycle T+N_PIX+2.
- done pulse occurs at cycle T+N_IMG·(N_PIX+2)+1, which is T+31441 with defaults.
- ROM latency is exactly 1 cycle. pix_data is sampled in the cycle after its pix_en. No stall input is provided.
- rst mid-pass: all outputs take their reset values immediately, the FSM returns to IDLE, and partial counts are discarded. Weight RAM is retained.

## Test plan
- All weights 0, any pixels → 40 score_valid pulses with score=0 and pred=0; correct_cnt=20 at done.
- weight[0]=256, others 0; ROM pixel 0 = 10 for img<20, 0 otherwise → score=2560 and pred=1 for img 0..19, score=0 for img 20..39; correct_cnt=40.
- All weights −1, all pixels 255 → every score=−199920 and pred=0; correct_cnt=20.
- All weights 32767, all pixels 255 → every score=6550778640 (no wrap) and pred=1; correct_cnt=20.
- rst asserted during ACC of image 5 → outputs reset and busy=0. Then start without reloading weights → results identical to an uninterrupted pass.
- start and w_we pulsed while busy → no effect on results or timing. done arrives exactly 31441 cycles after the original start edge, with pix_addr sequence 0..31359 in order.
